bus_arbiter_rr: RTL and testbench

//   N-master round-robin arbiter onto one shared memory port.

---
 rtl/bus_arbiter_rr.sv | 161 ++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin arbiter funnelling NUM_MASTERS rd/wr/rsp pulse channels onto one memory port.
// Optional access timeout is compiled in when BUS_ARBITER_TIMEOUT_EN is defined.
module bus_arbiter_rr #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_rd_i,
    input  logic [NUM_MASTERS-1:0]            m_wr_i,
    input  logic [NUM_MASTERS-1:0]            m_flush_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    output logic [NUM_MASTERS-1:0]            m_rsp_o,
    output logic [NUM_MASTERS-1:0]            m_err_o,
    output logic [DATA_WIDTH-1:0]             m_rdata_o,
    output logic                              s_rd_o,
    output logic                              s_wr_o,
    output logic [ADDR_WIDTH-1:0]             s_addr_o,
    output logic [DATA_WIDTH-1:0]             s_wdata_o,
    input  logic                              s_rsp_i,
    input  logic [DATA_WIDTH-1:0]             s_rdata_i,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_o
);
    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic                   isWr_q, isWr_d;
    logic                   discard_q, discard_d;
    logic [NUM_MASTERS-1:0] request;
    logic                   found;
    logic [GW-1:0]          pick;
    logic [GW-1:0]          cand;
    logic                   suppress;

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign request = (m_rd_i | m_wr_i) & ~m_flush_i;

    // First requester found walking upward from the master after the last grant.
    always_comb begin
        found = 1'b0;
        pick  = grant_q;
        cand  = grant_q;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = GW'((int'(grant_q) + k) % NUM_MASTERS);
            if (!found && request[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        isWr_d    = isWr_q;
        discard_d = discard_q;
        m_rsp_o   = '0;
        m_err_o   = '0;
        m_rdata_o = '0;
        suppress  = discard_q | m_flush_i[grant_q];
`ifdef BUS_ARBITER_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d   = pick;
                    addr_d    = m_addr_i[int'(pick)*ADDR_WIDTH +: ADDR_WIDTH];
                    wdata_d   = m_wdata_i[int'(pick)*DATA_WIDTH +: DATA_WIDTH];
                    isWr_d    = m_wr_i[pick];
                    discard_d = 1'b0;
                    state_d   = ACCESS;
`ifdef BUS_ARBITER_TIMEOUT_EN
                    cnt_d     = '0;
`endif
                end
            end
            ACCESS: begin
                if (m_flush_i[grant_q]) begin
                    discard_d = 1'b1;
                end
                if (s_rsp_i) begin
                    if (!suppress) begin
                        m_rsp_o[grant_q] = 1'b1;
                        m_rdata_o        = s_rdata_i;
                    end
                    discard_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef BUS_ARBITER_TIMEOUT_EN
                // The counter holds the number of ACCESS cycles already elapsed, so this fires on cycle TIMEOUT_CYCLES.
                else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    if (!suppress) begin
                        m_rsp_o[grant_q] = 1'b1;
                        m_err_o[grant_q] = 1'b1;
                    end
                    discard_d = 1'b0;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= GW'(NUM_MASTERS - 1);
            addr_q    <= '0;
            wdata_q   <= '0;
            isWr_q    <= 1'b0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            isWr_q    <= isWr_d;
            discard_q <= discard_d;
        end
    end

`ifdef BUS_ARBITER_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign s_rd_o    = (state_q == ACCESS) && !isWr_q;
    assign s_wr_o    = (state_q == ACCESS) && isWr_q;
    assign s_addr_o  = addr_q;
    assign s_wdata_o = wdata_q;
    assign grant_o   = grant_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed and randomized checks of bus_arbiter_rr with three masters.
// Timeout behaviour is exercised when BUS_ARBITER_TIMEOUT_EN is defined.
module tb_bus_arbiter_rr;
    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk;
    logic            rst;
    logic [N-1:0]    m_rd_i, m_wr_i, m_flush_i;
    logic [N*AW-1:0] m_addr_i;
    logic [N*DW-1:0] m_wdata_i;
    logic [N-1:0]    m_rsp_o, m_err_o;
    logic [DW-1:0]   m_rdata_o;
    logic            s_rd_o, s_wr_o;
    logic [AW-1:0]   s_addr_o;
    logic [DW-1:0]   s_wdata_o;
    logic            s_rsp_i;
    logic [DW-1:0]   s_rdata_i;
    logic [1:0]      grant_o;

    int checks = 0;
    int errors = 0;
    int lastGrant;
    bit [N-1:0]  pend;
    bit          reqWr[N];
    logic [31:0] reqAddr[N];
    logic [31:0] reqData[N];

    bus_arbiter_rr #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .m_rd_i(m_rd_i), .m_wr_i(m_wr_i), .m_flush_i(m_flush_i),
        .m_addr_i(m_addr_i), .m_wdata_i(m_wdata_i),
        .m_rsp_o(m_rsp_o), .m_err_o(m_err_o), .m_rdata_o(m_rdata_o),
        .s_rd_o(s_rd_o), .s_wr_o(s_wr_o), .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
        .s_rsp_i(s_rsp_i), .s_rdata_i(s_rdata_i), .grant_o(grant_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // op: 0 = read, 1 = write, 2 = read and write together
    task automatic applyStimulus(input int m, input int op, input logic [31:0] addr, input logic [31:0] data);
        m_rd_i[m]              = (op != 1);
        m_wr_i[m]              = (op != 0);
        m_addr_i[m*AW +: AW]   = addr;
        m_wdata_i[m*DW +: DW]  = data;
    endtask

    function automatic int rrPick(input int last, input bit [N-1:0] p);
        for (int k = 1; k <= N; k++) begin
            if (p[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // Entered in the first ACCESS cycle; memory answers after 'delay' extra cycles; returns in the next IDLE cycle.
    task automatic runAccess(input int g, input int delay, input int flushAt, input logic [31:0] rdata,
                             input bit expWr, input logic [31:0] expAddr, input logic [31:0] expData);
        logic [N-1:0] oneHot;
        bit dropped;
        oneHot    = '0;
        oneHot[g] = 1'b1;
        dropped   = (flushAt >= 0);
        for (int c = 0; c <= delay; c++) begin
            s_rsp_i   = (c == delay);
            s_rdata_i = rdata;
            m_flush_i = (c == flushAt) ? oneHot : '0;
            settle();
            if (c == 0) begin
                checkOutput("grant_o", 64'(grant_o), 64'(g));
                checkOutput("s_wdata_o", 64'(s_wdata_o), 64'(expData));
            end
            checkOutput("s_rd_o", 64'(s_rd_o), 64'(!expWr));
            checkOutput("s_wr_o", 64'(s_wr_o), 64'(expWr));
            checkOutput("s_addr_o", 64'(s_addr_o), 64'(expAddr));
            if (c == delay) begin
                checkOutput("m_rsp_o", 64'(m_rsp_o), dropped ? 64'(0) : 64'(oneHot));
                checkOutput("m_rdata_o", 64'(m_rdata_o), dropped ? 64'(0) : 64'(rdata));
            end else begin
                checkOutput("m_rsp_o_wait", 64'(m_rsp_o), 64'(0));
            end
            checkOutput("m_err_o", 64'(m_err_o), 64'(0));
            nextCycle();
        end
        s_rsp_i   = 1'b0;
        s_rdata_i = '0;
        m_flush_i = '0;
        m_rd_i[g] = 1'b0;
        m_wr_i[g] = 1'b0;
        settle();
        checkOutput("done_s_rd_o", 64'(s_rd_o), 64'(0));
        checkOutput("done_s_wr_o", 64'(s_wr_o), 64'(0));
        checkOutput("done_m_rsp_o", 64'(m_rsp_o), 64'(0));
        checkOutput("done_grant_o", 64'(grant_o), 64'(g));
        nextCycle();
    endtask

    task automatic newRequest(input int i);
        int op;
        op         = int'($urandom_range(0, 2));
        pend[i]    = 1'b1;
        reqWr[i]   = (op != 0);
        reqAddr[i] = $urandom;
        reqData[i] = $urandom;
        applyStimulus(i, op, reqAddr[i], reqData[i]);
    endtask

    initial begin
        int g, d, f, idleM;
        rst       = 1'b1;
        m_rd_i    = '0;
        m_wr_i    = '0;
        m_flush_i = '0;
        m_addr_i  = '0;
        m_wdata_i = '0;
        s_rsp_i   = 1'b0;
        s_rdata_i = '0;
        pend      = '0;

        // Reset values
        nextCycle();
        nextCycle();
        checkOutput("rst_s_rd_o", 64'(s_rd_o), 64'(0));
        checkOutput("rst_s_wr_o", 64'(s_wr_o), 64'(0));
        checkOutput("rst_s_addr_o", 64'(s_addr_o), 64'(0));
        checkOutput("rst_s_wdata_o", 64'(s_wdata_o), 64'(0));
        checkOutput("rst_m_rsp_o", 64'(m_rsp_o), 64'(0));
        checkOutput("rst_m_err_o", 64'(m_err_o), 64'(0));
        checkOutput("rst_m_rdata_o", 64'(m_rdata_o), 64'(0));
        checkOutput("rst_grant_o", 64'(grant_o), 64'(N - 1));
        rst = 1'b0;

        // Master 0 read of 0x100 answered on the third ACCESS cycle
        $display("[TB] single read");
        applyStimulus(0, 0, 32'h100, 32'h0);
        nextCycle();
        runAccess(0, 2, -1, 32'hDEADBEEF, 1'b0, 32'h100, 32'h0);

        // No request, and a flushed request, both leave the arbiter idle
        nextCycle();
        settle();
        checkOutput("idle_s_rd_o", 64'(s_rd_o), 64'(0));
        applyStimulus(0, 0, 32'h104, 32'h0);
        m_flush_i = 3'b001;
        nextCycle();
        nextCycle();
        settle();
        checkOutput("flushidle_s_rd_o", 64'(s_rd_o), 64'(0));
        checkOutput("flushidle_m_rsp_o", 64'(m_rsp_o), 64'(0));
        m_rd_i    = '0;
        m_flush_i = '0;
        nextCycle();

        // Read and write together: write wins
        $display("[TB] rd+wr priority");
        applyStimulus(1, 2, 32'h20, 32'hA5A5A5A5);
        nextCycle();
        runAccess(1, 0, -1, 32'h0, 1'b1, 32'h20, 32'hA5A5A5A5);

        // Masters 0 and 1 continuously requesting alternate
        $display("[TB] fairness");
        applyStimulus(0, 0, 32'h1000, 32'h0);
        applyStimulus(1, 0, 32'h1010, 32'h0);
        for (int t = 0; t < 4; t++) begin
            nextCycle();
            runAccess(t % 2, 1, -1, 32'h5000 + 32'(t), 1'b0, 32'h1000 + 32'((t % 2) * 16), 32'h0);
            if (t < 3) applyStimulus(t % 2, 0, 32'h1000 + 32'((t % 2) * 16), 32'h0);
        end
        m_rd_i = '0;

        // Flush on the second ACCESS cycle, memory answers on the fourth
        $display("[TB] flush");
        applyStimulus(0, 0, 32'h200, 32'h0);
        nextCycle();
        runAccess(0, 3, 1, 32'h12345678, 1'b0, 32'h200, 32'h0);

`ifdef BUS_ARBITER_TIMEOUT_EN
        $display("[TB] timeout");
        applyStimulus(2, 0, 32'h300, 32'h0);
        nextCycle();
        s_rdata_i = 32'hFFFF0000;
        for (int c = 1; c <= TO; c++) begin
            settle();
            if (c < TO) begin
                checkOutput("to_wait_s_rd_o", 64'(s_rd_o), 64'(1));
                checkOutput("to_wait_m_rsp_o", 64'(m_rsp_o), 64'(0));
            end else begin
                checkOutput("to_m_rsp_o", 64'(m_rsp_o), 64'(3'b100));
                checkOutput("to_m_err_o", 64'(m_err_o), 64'(3'b100));
                checkOutput("to_m_rdata_o", 64'(m_rdata_o), 64'(0));
            end
            nextCycle();
        end
        m_rd_i[2] = 1'b0;
        s_rsp_i   = 1'b1;
        settle();
        checkOutput("to_after_s_rd_o", 64'(s_rd_o), 64'(0));
        checkOutput("late_rsp_m_rsp_o", 64'(m_rsp_o), 64'(0));
        nextCycle();
        s_rsp_i   = 1'b0;
        s_rdata_i = '0;
`else
        $display("[TB] no timeout");
        applyStimulus(2, 0, 32'h300, 32'h0);
        nextCycle();
        for (int c = 0; c < 12; c++) begin
            settle();
            checkOutput("nto_s_rd_o", 64'(s_rd_o), 64'(1));
            checkOutput("nto_m_err_o", 64'(m_err_o), 64'(0));
            checkOutput("nto_m_rsp_o", 64'(m_rsp_o), 64'(0));
            nextCycle();
        end
        runAccess(2, 0, -1, 32'hCAFEF00D, 1'b0, 32'h300, 32'h0);
`endif

        // Reset in the middle of an access
        $display("[TB] reset mid-access");
        applyStimulus(1, 0, 32'h140, 32'h0);
        nextCycle();
        settle();
        checkOutput("pre_rst_grant_o", 64'(grant_o), 64'(1));
        checkOutput("pre_rst_s_rd_o", 64'(s_rd_o), 64'(1));
        rst     = 1'b1;
        s_rsp_i = 1'b1;
        #1;
        checkOutput("midrst_s_rd_o", 64'(s_rd_o), 64'(0));
        checkOutput("midrst_grant_o", 64'(grant_o), 64'(N - 1));
        checkOutput("midrst_s_addr_o", 64'(s_addr_o), 64'(0));
        checkOutput("midrst_m_rsp_o", 64'(m_rsp_o), 64'(0));
        s_rsp_i = 1'b0;
        nextCycle();
        rst = 1'b0;
        applyStimulus(0, 0, 32'h180, 32'h0);
        nextCycle();
        runAccess(0, 1, -1, 32'h11112222, 1'b0, 32'h180, 32'h0);
        nextCycle();
        runAccess(1, 0, -1, 32'h33334444, 1'b0, 32'h140, 32'h0);
        m_rd_i    = '0;
        m_wr_i    = '0;
        lastGrant = 1;

        // Randomized traffic against the round-robin reference model
        $display("[TB] random traffic");
        for (int t = 0; t < 40; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) newRequest(i);
            end
            if (pend == '0) begin
                idleM = int'($urandom_range(0, N - 1));
                newRequest(idleM);
            end
            g = rrPick(lastGrant, pend);
            d = int'($urandom_range(0, 3));
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, d)) : -1;
            nextCycle();
            runAccess(g, d, f, $urandom, reqWr[g], reqAddr[g], reqData[g]);
            pend[g]   = 1'b0;
            lastGrant = g;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
